// File: rtl/sdram_tester_pkg.sv
// sdram_tester_pkg: shared FSM state encoding, LFSR tap mask and the
// address-derived default pattern for the AXI memory tester.
package sdram_tester_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      RD_REQ,
      RD_DATA,
      DONE
   } state_t;

   // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (state bits 15,13,12,10)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Address XOR mask; callers truncate the result to their data width,
   // which gives addr[DATA_WIDTH-1:0] ^ mask.
   function automatic logic [63:0] default_pattern(input logic [63:0] addr,
                                                   input logic [63:0] mask);
      return addr ^ mask;
   endfunction

endpackage

// File: rtl/axi_mem_tester_lfsr.sv
// tester_lfsr: 16-bit Fibonacci LFSR with synchronous seed load and step
// enable; load takes priority over step.
module tester_lfsr
   import sdram_tester_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic        step,
   input  logic [15:0] seed,
   output logic [15:0] state
);

   // Seed load or single shift per enabled cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= '0;
      end else if (load) begin
         state <= seed;
      end else if (step) begin
         state <= {state[14:0], ^(state & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/axi_mem_tester.sv
// axi_mem_tester: writes a pattern to every word in START_ADDR..END_ADDR over
// an AXI-style master, reads it back, counts mismatches, and guards every
// handshake with a watchdog.
// Build option: define AXI_MEM_TESTER_LFSR_EN to draw the pattern from a
// 16-bit LFSR (tester_lfsr) instead of the address XOR PATTERN_XOR pattern.
module axi_mem_tester
   import sdram_tester_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 25,
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned START_ADDR     = 0,
   parameter int unsigned END_ADDR       = 1023,
   parameter logic [15:0] PATTERN_XOR    = 16'hA5C3,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [15:0]           error_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam int unsigned           WDT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WDT_W-1:0]      WDT_LIMIT = WDT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] A_START   = ADDR_WIDTH'(START_ADDR);
   localparam logic [ADDR_WIDTH-1:0] A_END     = ADDR_WIDTH'(END_ADDR);

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] addr, addr_n;
   logic                  aw_v, aw_v_n, w_v, w_v_n, ar_v, ar_v_n, r_rdy, r_rdy_n;
   logic                  aw_ok, aw_ok_n, w_ok, w_ok_n;
   logic [15:0]           err_cnt, err_cnt_n;
   logic [ADDR_WIDTH-1:0] first_err, first_err_n;
   logic                  to_r, to_n, pass_r, pass_n;
   logic [WDT_W-1:0]      wdt, wdt_n;
   logic                  progress;
   logic                  aw_hs, w_hs, ar_hs, aw_acc, w_acc;
   logic [DATA_WIDTH-1:0] pat;

   assign aw_hs  = aw_v && m_axi_awready;
   assign w_hs   = w_v && m_axi_wready;
   assign ar_hs  = ar_v && m_axi_arready;
   // aw/w may complete on different edges; a beat is done once both have
   assign aw_acc = aw_ok || aw_hs;
   assign w_acc  = w_ok || w_hs;

`ifdef AXI_MEM_TESTER_LFSR_EN
   logic [15:0] lfsr_state;
   logic        lfsr_load, lfsr_step;

   // reseed on entry to the write phase and on the write->read transition
   assign lfsr_load = (state != WR_REQ && state_n == WR_REQ) ||
                      (state == WR_REQ && state_n == RD_REQ);
   assign lfsr_step = (state == WR_REQ && aw_acc && w_acc) ||
                      (state == RD_DATA && m_axi_rvalid);

   tester_lfsr u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (lfsr_load),
      .step    (lfsr_step),
      .seed    (PATTERN_XOR),
      .state   (lfsr_state)
   );

   assign pat = DATA_WIDTH'(lfsr_state);
`else
   assign pat = DATA_WIDTH'(default_pattern(64'(addr), 64'(PATTERN_XOR)));
`endif

   assign busy           = (state == WR_REQ) || (state == RD_REQ) || (state == RD_DATA);
   assign done           = (state == DONE);
   assign pass           = pass_r;
   assign timeout        = to_r;
   assign error_count    = err_cnt;
   assign first_err_addr = first_err;
   assign m_axi_awvalid  = aw_v;
   assign m_axi_wvalid   = w_v;
   assign m_axi_arvalid  = ar_v;
   assign m_axi_rready   = r_rdy;
   assign m_axi_awaddr   = (state == WR_REQ) ? addr : '0;
   assign m_axi_wdata    = (state == WR_REQ) ? pat : '0;
   assign m_axi_araddr   = (state == RD_REQ) ? addr : '0;

   // Next-state, handshake, status and watchdog logic
   always_comb begin
      state_n     = state;
      addr_n      = addr;
      aw_v_n      = aw_v;
      w_v_n       = w_v;
      ar_v_n      = ar_v;
      r_rdy_n     = r_rdy;
      aw_ok_n     = aw_ok;
      w_ok_n      = w_ok;
      err_cnt_n   = err_cnt;
      first_err_n = first_err;
      to_n        = to_r;
      pass_n      = pass_r;
      wdt_n       = wdt;
      progress    = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n     = WR_REQ;
               addr_n      = A_START;
               aw_v_n      = 1'b1;
               w_v_n       = 1'b1;
               ar_v_n      = 1'b0;
               r_rdy_n     = 1'b0;
               aw_ok_n     = 1'b0;
               w_ok_n      = 1'b0;
               err_cnt_n   = '0;
               first_err_n = '0;
               to_n        = 1'b0;
               pass_n      = 1'b0;
               wdt_n       = '0;
            end
         end
         WR_REQ: begin
            aw_ok_n  = aw_acc;
            w_ok_n   = w_acc;
            aw_v_n   = aw_v && !m_axi_awready;
            w_v_n    = w_v && !m_axi_wready;
            progress = aw_hs || w_hs;
            if (aw_acc && w_acc) begin
               aw_ok_n = 1'b0;
               w_ok_n  = 1'b0;
               if (addr == A_END) begin
                  state_n = RD_REQ;
                  addr_n  = A_START;
                  aw_v_n  = 1'b0;
                  w_v_n   = 1'b0;
                  ar_v_n  = 1'b1;
                  r_rdy_n = 1'b1;
               end else begin
                  addr_n = addr + 1'b1;
                  aw_v_n = 1'b1;
                  w_v_n  = 1'b1;
               end
            end
         end
         RD_REQ: begin
            progress = ar_hs;
            if (ar_hs) begin
               ar_v_n  = 1'b0;
               state_n = RD_DATA;
            end
         end
         RD_DATA: begin
            progress = m_axi_rvalid;
            if (m_axi_rvalid) begin
               if (m_axi_rdata != pat) begin
                  if (err_cnt != 16'hFFFF) err_cnt_n = err_cnt + 1'b1;
                  if (err_cnt == '0) first_err_n = addr;
               end
               if (addr == A_END) begin
                  state_n = DONE;
                  r_rdy_n = 1'b0;
                  pass_n  = (err_cnt_n == '0) && !to_r;
               end else begin
                  addr_n  = addr + 1'b1;
                  state_n = RD_REQ;
                  ar_v_n  = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Every transition out of a busy state is also a handshake, so
      // reloading on progress covers reload on state entry as well.
      if (busy) begin
         if (progress) begin
            wdt_n = '0;
         end else if (wdt == WDT_LIMIT) begin
            state_n = DONE;
            aw_v_n  = 1'b0;
            w_v_n   = 1'b0;
            ar_v_n  = 1'b0;
            r_rdy_n = 1'b0;
            aw_ok_n = 1'b0;
            w_ok_n  = 1'b0;
            to_n    = 1'b1;
            pass_n  = 1'b0;
            wdt_n   = '0;
         end else begin
            wdt_n = wdt + 1'b1;
         end
      end
   end

   // State and datapath registers; reset clears every output immediately
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         addr      <= '0;
         aw_v      <= 1'b0;
         w_v       <= 1'b0;
         ar_v      <= 1'b0;
         r_rdy     <= 1'b0;
         aw_ok     <= 1'b0;
         w_ok      <= 1'b0;
         err_cnt   <= '0;
         first_err <= '0;
         to_r      <= 1'b0;
         pass_r    <= 1'b0;
         wdt       <= '0;
      end else begin
         state     <= state_n;
         addr      <= addr_n;
         aw_v      <= aw_v_n;
         w_v       <= w_v_n;
         ar_v      <= ar_v_n;
         r_rdy     <= r_rdy_n;
         aw_ok     <= aw_ok_n;
         w_ok      <= w_ok_n;
         err_cnt   <= err_cnt_n;
         first_err <= first_err_n;
         to_r      <= to_n;
         pass_r    <= pass_n;
         wdt       <= wdt_n;
      end
   end

endmodule

// File: doc/axi_mem_tester.md
AXI_MEM_TESTER -- requirements
Module: axi_mem_tester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 25, AXI byte-free word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data word width.
REQ-003 SHALL have parameter START_ADDR, default 0, first word address tested.
REQ-004 SHALL have parameter END_ADDR, default 1023, last word address tested (inclusive, END_ADDR >= START_ADDR).
REQ-005 SHALL have parameter PATTERN_XOR, default 16'hA5C3, pattern mask/seed.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waiting on any handshake.
REQ-007 SHALL have ports: clk in 1 clock; reset_n in 1 asynchronous active-low reset; one clock, all logic on rising edge of clk.
REQ-008 SHALL have ports: start in 1 run request; busy out 1; done out 1; pass out 1; timeout out 1; error_count out 16; first_err_addr out ADDR_WIDTH.
REQ-009 SHALL have AXI master ports: m_axi_awaddr out ADDR_WIDTH; m_axi_awvalid out 1; m_axi_awready in 1; m_axi_wdata out DATA_WIDTH; m_axi_wvalid out 1; m_axi_wready in 1.
REQ-010 SHALL have AXI master ports: m_axi_araddr out ADDR_WIDTH; m_axi_arvalid out 1; m_axi_arready in 1; m_axi_rdata in DATA_WIDTH; m_axi_rvalid in 1; m_axi_rready out 1.

Function
REQ-011 SHALL implement FSM states IDLE, WR_REQ, RD_REQ, RD_DATA, DONE; IDLE->WR_REQ on start, addr=START_ADDR, status cleared.
REQ-012 WR_REQ SHALL assert awvalid and wvalid together with awaddr=addr, wdata=pattern(addr); each valid drops the cycle after its own ready is sampled high; both accepted -> addr+1, or if addr==END_ADDR -> RD_REQ with addr=START_ADDR.
REQ-013 RD_REQ SHALL assert arvalid and rready with araddr=addr; arready sampled high -> arvalid low, RD_DATA.
REQ-014 RD_DATA SHALL hold rready high; on rvalid compare rdata to pattern(addr); if addr==END_ADDR -> DONE, else addr+1, RD_REQ.
REQ-015 Mismatch SHALL increment error_count, saturating at 16'hFFFF; first mismatch SHALL latch first_err_addr.
REQ-016 Default pattern(addr) SHALL be addr[DATA_WIDTH-1:0] XOR PATTERN_XOR.
REQ-017 A per-handshake watchdog SHALL reload on each state entry and each accepted handshake; reaching TIMEOUT_CYCLES SHALL drop all valids, set timeout, go DONE.
REQ-018 DONE SHALL assert done, pass=(error_count==0 && !timeout); start in DONE SHALL restart as from IDLE, clearing error_count, first_err_addr, timeout, pass, done.
REQ-019 busy SHALL be high in WR_REQ, RD_REQ, RD_DATA only; start while busy SHALL be ignored.
REQ-020 rvalid outside RD_DATA SHALL be ignored; START_ADDR==END_ADDR SHALL perform exactly one write and one read.

Reset
REQ-021 reset_n low SHALL immediately force IDLE and all outputs 0 (valids, rready, busy, done, pass, timeout, error_count, first_err_addr, addresses, wdata), including mid-transaction.
REQ-022 Operation SHALL resume only on a start sampled after reset_n deassertion.

Configuration
REQ-023 Macro AXI_MEM_TESTER_LFSR_EN defined: pattern SHALL come from a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seeded with PATTERN_XOR at start of write and again at start of read phase, stepped once per accepted write/read; undefined: REQ-016 pattern, no LFSR logic.

Structure
REQ-024 Package sdram_tester_pkg SHALL hold the FSM state encoding, LFSR tap constant, and the default pattern function.
REQ-025 Sub-module tester_lfsr (seed load, step enable, 16-bit state out) SHALL be instantiated only under AXI_MEM_TESTER_LFSR_EN.

Verification
REQ-026 Ideal memory model, START_ADDR=0, END_ADDR=3, start pulse -> 4 writes (0:A5C3, 1:A5C2, 2:A5C1, 3:A5C0), 4 reads, done=1, pass=1, error_count=0.
REQ-027 Model corrupts read of addr 2 to 16'h0000 -> error_count=1, first_err_addr=2, pass=0.
REQ-028 awready high 3 cycles before wready -> awvalid drops after awready, wvalid held until wready, exactly one write per address.
REQ-029 arready tied low, TIMEOUT_CYCLES=15 -> timeout=1, done=1, pass=0, arvalid low within 16 cycles of RD_REQ entry.
REQ-030 reset_n pulsed low during write of addr 1 -> all outputs 0 same cycle; later start reruns from addr 0 and passes.
REQ-031 With AXI_MEM_TESTER_LFSR_EN, END_ADDR=7 -> read-phase expected values equal write-phase wdata sequence; pass=1.
